pipe_rca_n: RTL and testbench

Parametrised pipelined ripple-carry adder/subtractor: WIDTH-bit operands split into CHUNK-bit slices, one slice resolved per pipeline stage, carry rippled stage-to-stage. Adds valid/ready flow control, synchronous reset, subtract mode and optional signed-overflow output to the fixed 4-bit, 1-bit-per-stage adder. Sits in the datapath wherever a high-fmax, fully pipelined add/sub with one result per cycle is needed.

---
 rtl/pipe_rca_n.sv | 215 +++++++++++++++++++++
 tb/tb_pipe_rca_n.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rca_n.sv
// pipe_rca_n -- pipelined ripple-carry adder/subtractor.
//
// WIDTH-bit operands are split into CHUNK-bit slices. Stage k resolves slice k
// with a CHUNK-bit ripple and passes its carry to stage k+1 through a register,
// so the pipeline is STAGES = WIDTH/CHUNK deep and accepts one beat per cycle.
//
// Each stage register holds:
//   - a valid bit (bubbles are kept in their slot, never collapsed),
//   - the carry out of the slice it resolved,
//   - every sum slice resolved so far, already placed at its final position,
//   - the operand bits still to be consumed, shifted down so the next slice
//     is always at bits [CHUNK-1:0].
//
// Subtract mode is folded in at the input only: B is inverted and the carry-in
// is inverted there, so downstream stages see a plain adder.
//
// Flow control is a single global advance: adv = ~Out_valid | Out_ready.
// When adv is low every register, bubbles included, holds. In_ready is adv,
// which makes In_ready combinational from Out_ready on purpose.
//
// Optional feature macro: PIPE_RCA_OVF_EN
//   defined   -> Ovf = carry into MSB XOR carry out of MSB, computed in the
//                last stage and registered alongside Sum.
//   undefined -> no overflow logic; Ovf is tied to 0.

`timescale 1ns/1ps

module pipe_rca_n #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    // Reject configurations that cannot be sliced evenly.
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("pipe_rca_n: WIDTH must be >= 2");
        end
        if (CHUNK < 1) begin : g_bad_chunk_size
            $error("pipe_rca_n: CHUNK must be >= 1");
        end
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk_div
            $error("pipe_rca_n: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    // CHUNK-bit ripple adder: returns {carry_out, sum}.
    function automatic logic [CHUNK:0] ripple_chunk(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             cin
    );
        logic             c;
        logic [CHUNK-1:0] s;
        c = cin;
        s = {CHUNK{1'b0}};
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        return {c, s};
    endfunction

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic             r_vld [STAGES];
    logic             r_cy  [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];

    // ------------------------------------------------------------------
    // Stage inputs and next-state values
    // ------------------------------------------------------------------
    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    logic             w_vld_in  [STAGES];
    logic             w_cy_in   [STAGES];
    logic [WIDTH-1:0] w_sum_in  [STAGES];
    logic [WIDTH-1:0] w_a_in    [STAGES];
    logic [WIDTH-1:0] w_b_in    [STAGES];

    logic [CHUNK:0]   w_chunk   [STAGES];
    logic             w_cy_nxt  [STAGES];
    logic [WIDTH-1:0] w_sum_nxt [STAGES];
    logic [WIDTH-1:0] w_a_nxt   [STAGES];
    logic [WIDTH-1:0] w_b_nxt   [STAGES];

    assign w_adv    = ~r_vld[STAGES-1] | Out_ready;
    assign In_ready = w_adv;

    // Input conditioning: fold subtract into inverted B and inverted carry-in.
    always_comb begin
        w_b_eff = B;
        w_c0    = Cin;
        if (Sub) begin
            w_b_eff = ~B;
            w_c0    = ~Cin;
        end else begin
            w_b_eff = B;
            w_c0    = Cin;
        end
    end

    // Route each stage's inputs: stage 0 from the ports, stage k from stage k-1.
    always_comb begin
        w_vld_in[0] = In_valid;
        w_cy_in[0]  = w_c0;
        w_sum_in[0] = {WIDTH{1'b0}};
        w_a_in[0]   = A;
        w_b_in[0]   = w_b_eff;
        for (int k = 1; k < STAGES; k++) begin
            w_vld_in[k] = r_vld[k-1];
            w_cy_in[k]  = r_cy[k-1];
            w_sum_in[k] = r_sum[k-1];
            w_a_in[k]   = r_a[k-1];
            w_b_in[k]   = r_b[k-1];
        end
    end

    // Per-stage slice ripple: resolve the low slice, place it, shift operands down.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_chunk[k]   = ripple_chunk(w_a_in[k][CHUNK-1:0],
                                        w_b_in[k][CHUNK-1:0],
                                        w_cy_in[k]);
            w_cy_nxt[k]  = w_chunk[k][CHUNK];
            w_sum_nxt[k] = w_sum_in[k]
                         | (WIDTH'(w_chunk[k][CHUNK-1:0]) << (k * CHUNK));
            w_a_nxt[k]   = w_a_in[k] >> CHUNK;
            w_b_nxt[k]   = w_b_in[k] >> CHUNK;
        end
    end

    // Pipeline registers: reset clears everything, otherwise move only on advance.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_cy[k]  <= 1'b0;
                r_sum[k] <= {WIDTH{1'b0}};
                r_a[k]   <= {WIDTH{1'b0}};
                r_b[k]   <= {WIDTH{1'b0}};
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_vld_in[k];
                r_cy[k]  <= w_cy_nxt[k];
                r_sum[k] <= w_sum_nxt[k];
                r_a[k]   <= w_a_nxt[k];
                r_b[k]   <= w_b_nxt[k];
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= r_vld[k];
                r_cy[k]  <= r_cy[k];
                r_sum[k] <= r_sum[k];
                r_a[k]   <= r_a[k];
                r_b[k]   <= r_b[k];
            end
        end
    end

    assign Out_valid = r_vld[STAGES-1];
    assign Sum       = r_sum[STAGES-1];
    assign Cout      = r_cy[STAGES-1];

`ifdef PIPE_RCA_OVF_EN
    logic w_msb_cin;
    logic w_ovf_nxt;
    logic r_ovf;

    // Signed overflow in the last stage: carry into MSB recovered from a^b^sum.
    always_comb begin
        w_msb_cin = w_a_in[STAGES-1][CHUNK-1]
                  ^ w_b_in[STAGES-1][CHUNK-1]
                  ^ w_chunk[STAGES-1][CHUNK-1];
        w_ovf_nxt = w_msb_cin ^ w_chunk[STAGES-1][CHUNK];
    end

    // Overflow flag register, advancing in lockstep with the last stage.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_ovf_nxt;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign Ovf = r_ovf;
`else
    assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_rca_n.sv
// Testbench for pipe_rca_n (WIDTH=16, CHUNK=4). Directed vectors with
// hand-computed results are pushed to a scoreboard queue on acceptance; a
// separate monitor pops and compares whenever a result beat is handed off.

`timescale 1ns/1ps

module tb_pipe_rca_n;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int ST = W / C;

`ifdef PIPE_RCA_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         Clk;
    logic         Rst;
    logic         In_valid;
    logic         In_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Sub;
    logic         Out_valid;
    logic         Out_ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;

    pipe_rca_n #(.WIDTH(W), .CHUNK(C)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every completed output handshake.
    always @(negedge Clk) begin
        exp_t e;
        if (!Rst && Out_valid && Out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got sum %0h with nothing outstanding (cycle %0d)", Sum, cyc);
            end else begin
                e = q.pop_front();
                chk("sum",  {16'h0000, Sum},  {16'h0000, e.s});
                chk("cout", {31'h0, Cout},    {31'h0, e.c});
                chk("ovf",  {31'h0, Ovf},     {31'h0, e.o});
                if (e.lat) chk("latency", cyc - e.acc, ST - 1);
            end
        end
    end

    // Present one beat; push its expected result at the acceptance edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sb,
                         input logic [W-1:0] s, input logic co, input logic ov,
                         input bit lat);
        exp_t e;
        int   n;
        A = a; B = b; Cin = ci; Sub = sb; In_valid = 1'b1;
        n = 0;
        @(negedge Clk);
        while (!In_ready && n < 50) begin
            n++;
            @(negedge Clk);
        end
        if (In_ready) begin
            e.s = s; e.c = co; e.o = OVF_ON ? ov : 1'b0;
            e.acc = cyc + 1; e.lat = lat;
            q.push_back(e);
        end else begin
            total++;
            bad++;
            $display("FAIL accept_timeout: In_ready stayed 0 for beat a=%0h b=%0h", a, b);
        end
        @(posedge Clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge Clk);
            n++;
        end
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        Rst = 1'b1; In_valid = 1'b1; A = 16'h1234; B = 16'h5678;
        Cin = 1'b0; Sub = 1'b0; Out_ready = 1'b1;

        // Reset held 2 cycles with In_valid high
        repeat (2) begin @(posedge Clk); #1; end
        chk("rst_out_valid", {31'h0, Out_valid}, 0);
        chk("rst_sum",       {16'h0, Sum},       0);
        chk("rst_cout",      {31'h0, Cout},      0);
        chk("rst_ovf",       {31'h0, Ovf},       0);
        chk("rst_in_ready",  {31'h0, In_ready},  1);
        Rst = 1'b0; In_valid = 1'b0;
        repeat (8) @(posedge Clk); #1;
        chk("idle_after_rst", {31'h0, Out_valid}, 0);

        // Directed: add wrap, subtract with borrow, signed overflow
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        In_valid = 1'b0;
        drain();

        // Streaming: 8 back-to-back beats, Cin/Sub mixed
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        issue(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b1);
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        issue(16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
        issue(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        issue(16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0, 1'b1);
        issue(16'hF0F0, 16'h0F0F, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        In_valid = 1'b0;
        drain();

        // Backpressure: stall 3 cycles once the first of 4 beats is presented
        issue(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0, 1'b0);
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        issue(16'h7000, 16'h1000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        issue(16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        In_valid = 1'b0;
        Out_ready = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk("stall_out_valid", {31'h0, Out_valid}, 1);
            chk("stall_in_ready",  {31'h0, In_ready},  0);
            chk("stall_sum",       {16'h0, Sum},       32'h0FFF);
            chk("stall_cout",      {31'h0, Cout},      1);
            @(posedge Clk); #1;
        end
        Out_ready = 1'b1;
        drain();

        // Reset mid-flight: 3 beats discarded, next beat has normal latency
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
        issue(16'h4444, 16'h1111, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b0, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        In_valid = 1'b0;
        Rst = 1'b1;
        q.delete();
        @(posedge Clk); #1;
        Rst = 1'b0;
        chk("midrst_out_valid", {31'h0, Out_valid}, 0);
        chk("midrst_in_ready",  {31'h0, In_ready},  1);
        issue(16'h2222, 16'h1111, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b1);
        In_valid = 1'b0;
        drain();
        repeat (8) @(posedge Clk); #1;
        chk("final_idle", {31'h0, Out_valid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
